// File: rtl/iir_filter_tdm.sv
// Direct-form-I IIR filter sharing one signed MAC over all b/a taps; y[n] is sampled with out_valid on edge 2*ORDER+3 after accept.
// in_ready is low while a sample is in flight (the source holds the sample); optional sticky ovf_flag port when IIR_OVF_FLAG_EN is defined.
module iir_filter_tdm #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 24,
    parameter int FRAC_BITS = 22,
    parameter int ORDER     = 11,
    parameter int ACC_W     = 56
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_W-1:0]     in_data,
    output logic                         in_ready,
    input  logic                         coef_we,
    input  logic                         coef_sel,
    input  logic [$clog2(ORDER+1)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]     coef_wdata,
    output logic                         out_valid,
    output logic signed [DATA_W-1:0]     out_data
`ifdef IIR_OVF_FLAG_EN
    ,
    output logic                         ovf_flag
`endif
);
    localparam int ADDR_W = $clog2(ORDER + 1);
    localparam int CNT_W  = $clog2(2 * ORDER + 1);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [CNT_W-1:0]         ORD_C    = CNT_W'(ORDER);
    localparam logic [CNT_W-1:0]         LAST_C   = CNT_W'(2 * ORDER);
    localparam logic [ADDR_W-1:0]        ADDR_MAX = ADDR_W'(ORDER);
    localparam logic signed [COEF_W-1:0] B0_RST   = COEF_W'(1) << FRAC_BITS;
    localparam logic signed [ACC_W-1:0]  HALF     = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'(D_MAX);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = ACC_W'(D_MIN);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [0:ORDER];
    logic signed [DATA_W-1:0] y_q [0:ORDER-1];
    logic signed [COEF_W-1:0] b_q [0:ORDER];
    logic signed [COEF_W-1:0] a_q [0:ORDER];
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;

    logic                     use_a;
    logic [ADDR_W-1:0]        tap_b, tap_a;
    logic signed [DATA_W-1:0] mul_x;
    logic signed [COEF_W-1:0] mul_c;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, rnd_sum, r_full;
    logic                     clip_hi, clip_lo;
    logic signed [DATA_W-1:0] sat_val;
    logic                     accept, coef_ok;

    // Taps 0..ORDER walk the b/x bank, ORDER+1..2*ORDER walk the a/y bank.
    always_comb begin
        use_a    = (k_q > ORD_C);
        tap_b    = ADDR_W'(k_q);
        tap_a    = ADDR_W'(k_q - ORD_C);
        mul_x    = use_a ? y_q[tap_a - ADDR_W'(1)] : x_q[tap_b];
        mul_c    = use_a ? a_q[tap_a] : b_q[tap_b];
        prod     = PROD_W'(mul_x) * PROD_W'(mul_c);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        rnd_sum  = acc_q + HALF;
        r_full   = rnd_sum >>> FRAC_BITS;
        clip_hi  = (r_full > SAT_MAX);
        clip_lo  = (r_full < SAT_MIN);
        sat_val  = clip_hi ? D_MAX : (clip_lo ? D_MIN : DATA_W'(r_full));
    end

    // The result registers at the end of ROUND, so out_valid is seen during OUT,
    // where the next sample may already be accepted.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        in_ready = (state_q == S_IDLE) || (state_q == S_OUT);
        accept   = in_valid && in_ready;
        coef_ok  = coef_we && in_ready && (coef_addr <= ADDR_MAX) &&
                   !(coef_sel && (coef_addr == '0));
        case (state_q)
            S_IDLE, S_OUT: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = S_MAC;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            S_MAC: begin
                acc_d = use_a ? (acc_q - prod_ext) : (acc_q + prod_ext);
                if (k_q == LAST_C) begin
                    state_d = S_ROUND;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_ROUND: state_d = S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i <= ORDER; i++) begin
                x_q[i] <= '0;
                b_q[i] <= (i == 0) ? B0_RST : '0;
                a_q[i] <= '0;
            end
            for (int i = 0; i < ORDER; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= (state_q == S_ROUND);
            if (accept) begin
                x_q[0] <= in_data;
                for (int i = 1; i <= ORDER; i++) begin
                    x_q[i] <= x_q[i-1];
                end
            end
            if (state_q == S_ROUND) begin
                out_data_q <= sat_val;
                y_q[0]     <= sat_val;
                for (int i = 1; i < ORDER; i++) begin
                    y_q[i] <= y_q[i-1];
                end
            end
            if (coef_ok) begin
                if (coef_sel) begin
                    a_q[coef_addr] <= coef_wdata;
                end else begin
                    b_q[coef_addr] <= coef_wdata;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef IIR_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_ROUND) && (clip_hi || clip_lo)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_flag = ovf_q;
`endif

endmodule
